// File: rtl/fu_sw_op_id.sv
// fu_sw_op_id: identifies the sel code of a fu_sw 2-input function unit from a
// stream of observed (a, b, y) samples, by candidate elimination over
// {AND, OR, XOR, XNOR}, with a timeout after MAX_SAMPLES samples.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      begin identification (pulse or level)
//   in_valid   in   1      sample (a, b, y) valid
//   in_ready   out  1      sample accepted this cycle when in_valid is high
//   a, b, y    in   1      observed fu_sw inputs and output
//   busy       out  1      identification in progress
//   done       out  1      unique op found, sel_out valid
//   sel_out    out  2      identified sel code (00 AND, 01 OR, 10 XOR, 11 XNOR)
//   err        out  1      identification failed
//   err_code   out  2      01 no candidate left, 10 ambiguous after MAX_SAMPLES
//   sample_cnt out  CNT_W  samples consumed in the current/last run
// All outputs are registered.
module fu_sw_op_id #(
  parameter int unsigned MAX_SAMPLES = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a,
  input  logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic [1:0]       sel_out,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] sample_cnt
);

  localparam int unsigned NUM_OPS = 4;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned POP_W   = 3;

  localparam logic [SEL_W-1:0] ERR_NONE         = 2'b00;
  localparam logic [SEL_W-1:0] ERR_INCONSISTENT = 2'b01;
  localparam logic [SEL_W-1:0] ERR_AMBIGUOUS    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2,
    ST_FAIL    = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_OPS-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [SEL_W-1:0]     err_code_q, err_code_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 in_ready_q, in_ready_d;
  logic                 busy_q, busy_d;

  logic [NUM_OPS-1:0]   match;
  logic [NUM_OPS-1:0]   nmask;
  logic [POP_W-1:0]     nmask_pop;
  logic [SEL_W-1:0]     nmask_idx;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 handshake;

  // Number of surviving candidates.
  function automatic logic [POP_W-1:0] popcnt4(input logic [NUM_OPS-1:0] m);
    logic [POP_W-1:0] s;
    s = '0;
    for (int i = 0; i < int'(NUM_OPS); i++) begin
      s = s + POP_W'(m[i]);
    end
    return s;
  endfunction

  // Index of the lowest set bit; only meaningful when exactly one bit is set.
  function automatic logic [SEL_W-1:0] idx4(input logic [NUM_OPS-1:0] m);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = NUM_OPS - 1; i >= 0; i--) begin
      if (m[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

  // Which candidate functions agree with the observed sample.
  always_comb begin
    match[0] = ((a & b) == y);
    match[1] = ((a | b) == y);
    match[2] = ((a ^ b) == y);
    match[3] = ((~(a ^ b)) == y);
  end

  assign nmask     = mask_q & match;
  assign nmask_pop = popcnt4(nmask);
  assign nmask_idx = idx4(nmask);
  assign cnt_inc   = cnt_q + CNT_W'(1);
  // in_ready_q is only ever high in COLLECT.
  assign handshake = in_valid & in_ready_q;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mask_q     <= '1;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      sel_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      sel_q      <= sel_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    sel_d      = sel_q;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) begin
          state_d    = ST_COLLECT;
          mask_d     = '1;
          cnt_d      = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          sel_d      = '0;
        end
      end
      ST_COLLECT: begin
        // start is ignored here; only accepted samples advance the run.
        if (handshake) begin
          mask_d = nmask;
          cnt_d  = cnt_inc;
          if (nmask_pop == POP_W'(0)) begin
            state_d    = ST_FAIL;
            err_d      = 1'b1;
            err_code_d = ERR_INCONSISTENT;
          end else if (nmask_pop == POP_W'(1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            sel_d   = nmask_idx;
          end else if (cnt_inc == CNT_W'(MAX_SAMPLES)) begin
            state_d    = ST_FAIL;
            err_d      = 1'b1;
            err_code_d = ERR_AMBIGUOUS;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered handshake/status flags follow the next state.
    in_ready_d = (state_d == ST_COLLECT);
    busy_d     = (state_d == ST_COLLECT);
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sel_out    = sel_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign sample_cnt = cnt_q;

endmodule
